// File: rtl/histogram_control_param_if.sv
// Pixel-stream and bin-RAM signal bundle for histogram_control_param.
// master = controller side, slave = pixel source plus bin RAM.
interface histogram_control_param_if #(
   parameter int unsigned PIXEL_WIDTH = 8,
   parameter int unsigned BIN_BITS    = 8,
   parameter int unsigned COUNT_WIDTH = 16
);
   logic                   pixel_valid;
   logic [PIXEL_WIDTH-1:0] pixel_data;
   logic                   pixel_ready;
   logic                   input_memory_read_finished;
   logic                   bin_rd_en;
   logic [BIN_BITS-1:0]    bin_rd_addr;
   logic [COUNT_WIDTH-1:0] bin_rd_data;
   logic                   bin_wr_en;
   logic [BIN_BITS-1:0]    bin_wr_addr;
   logic [COUNT_WIDTH-1:0] bin_wr_data;

   modport master (
      input  pixel_valid, pixel_data, input_memory_read_finished, bin_rd_data,
      output pixel_ready, bin_rd_en, bin_rd_addr, bin_wr_en, bin_wr_addr, bin_wr_data
   );

   modport slave (
      output pixel_valid, pixel_data, input_memory_read_finished, bin_rd_data,
      input  pixel_ready, bin_rd_en, bin_rd_addr, bin_wr_en, bin_wr_addr, bin_wr_data
   );
endinterface

// File: rtl/histogram_control_param.sv
// Histogram pass sequencer: clears the bin RAM, accumulates a pixel stream with a
// two-stage read-modify-write pipeline (same-bin forwarding), then reports completion.
module histogram_control_param #(
   parameter int unsigned PIXEL_WIDTH  = 8,
   parameter int unsigned BIN_BITS     = 8,
   parameter int unsigned COUNT_WIDTH  = 16,
   parameter bit          SATURATE     = 1'b1,
   parameter int unsigned PIXCNT_WIDTH = 20
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start_histogram,
   histogram_control_param_if.master bus,
   output logic                    busy,
   output logic                    all_pixel_written,
   output logic                    histogram_done,
   output logic [PIXCNT_WIDTH-1:0] pixel_count
);
   localparam int unsigned SHIFT = PIXEL_WIDTH - BIN_BITS;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_DONE} state_t;

   state_t                 state, state_nxt;
   logic                   fin_q;
   logic [BIN_BITS-1:0]    clr_addr;
   logic                   s2_valid;
   logic [BIN_BITS-1:0]    s2_bin;
   logic                   fwd_valid;
   logic [BIN_BITS-1:0]    fwd_bin;
   logic [COUNT_WIDTH-1:0] fwd_val;

   logic                   launch_c;
   logic                   accept_c;
   logic [BIN_BITS-1:0]    pix_bin_c;
   logic [COUNT_WIDTH-1:0] base_c;
   logic [COUNT_WIDTH-1:0] new_c;

   // Next-state decode
   always_comb begin
      state_nxt = state;
      launch_c  = 1'b0;
      unique case (state)
         S_IDLE:  if (start_histogram) begin launch_c = 1'b1; state_nxt = S_CLEAR; end
         S_CLEAR: if (clr_addr == '1) state_nxt = S_ACCUM;
         S_ACCUM: if (bus.input_memory_read_finished || fin_q) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_DONE;
         S_DONE:  if (start_histogram) begin launch_c = 1'b1; state_nxt = S_CLEAR; end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Stage 1 accept/read and stage 2 increment with forwarding of the previous write
   always_comb begin
      accept_c  = bus.pixel_valid && bus.pixel_ready;
      pix_bin_c = BIN_BITS'(bus.pixel_data >> SHIFT);
      base_c    = (fwd_valid && (fwd_bin == s2_bin)) ? fwd_val : bus.bin_rd_data;
      new_c     = (SATURATE && (&base_c)) ? base_c : base_c + COUNT_WIDTH'(1);

      bus.bin_rd_en   = accept_c;
      bus.bin_rd_addr = accept_c ? pix_bin_c : '0;
      bus.bin_wr_en   = 1'b0;
      bus.bin_wr_addr = '0;
      bus.bin_wr_data = '0;
      if (state == S_CLEAR) begin
         bus.bin_wr_en   = 1'b1;
         bus.bin_wr_addr = clr_addr;
      end else if (s2_valid) begin
         bus.bin_wr_en   = 1'b1;
         bus.bin_wr_addr = s2_bin;
         bus.bin_wr_data = new_c;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state             <= S_IDLE;
         busy              <= 1'b0;
         all_pixel_written <= 1'b0;
         histogram_done    <= 1'b0;
         bus.pixel_ready   <= 1'b0;
         pixel_count       <= '0;
         fin_q             <= 1'b0;
         clr_addr          <= '0;
         s2_valid          <= 1'b0;
         s2_bin            <= '0;
         fwd_valid         <= 1'b0;
         fwd_bin           <= '0;
         fwd_val           <= '0;
      end else begin
         state             <= state_nxt;
         busy              <= (state_nxt == S_CLEAR) || (state_nxt == S_ACCUM) ||
                              (state_nxt == S_DRAIN);
         all_pixel_written <= (state_nxt == S_DONE);
         histogram_done    <= (state_nxt == S_DONE) && (state != S_DONE);
         bus.pixel_ready   <= (state_nxt == S_ACCUM);

         if (launch_c) begin
            pixel_count <= '0;
            fin_q       <= 1'b0;
            clr_addr    <= '0;
         end else begin
            if (state == S_CLEAR) clr_addr <= clr_addr + BIN_BITS'(1);
            if (accept_c && (pixel_count != '1)) pixel_count <= pixel_count + PIXCNT_WIDTH'(1);
            if ((state == S_ACCUM) && bus.input_memory_read_finished) fin_q <= 1'b1;
         end

         s2_valid <= accept_c;
         if (accept_c) s2_bin <= pix_bin_c;
         fwd_valid <= s2_valid;
         fwd_bin   <= s2_bin;
         fwd_val   <= new_c;
      end
   end
endmodule

// File: tb/tb_histogram_control_param.sv
// Directed bench: one stimulus stream drives a 16-bit saturating, a 4-bit saturating
// and a 4-bit wrapping controller, each against its own behavioural bin RAM.
module tb_histogram_control_param;
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       pv    = 1'b0;
   logic       fin   = 1'b0;
   logic       fill  = 1'b1;
   logic [7:0] pd    = 8'd0;

   logic        busy [3];
   logic        apw  [3];
   logic        hd   [3];
   logic [19:0] pcnt [3];

   int checks = 0;
   int errors = 0;
   int wr_cnt0 = 0;
   int done_cnt = 0;

   always #5 clock = ~clock;

   histogram_control_param_if #(.PIXEL_WIDTH(8), .BIN_BITS(8), .COUNT_WIDTH(16)) hif0 ();
   histogram_control_param_if #(.PIXEL_WIDTH(8), .BIN_BITS(8), .COUNT_WIDTH(4))  hif1 ();
   histogram_control_param_if #(.PIXEL_WIDTH(8), .BIN_BITS(8), .COUNT_WIDTH(4))  hif2 ();

   assign hif0.pixel_valid = pv;  assign hif0.pixel_data = pd;  assign hif0.input_memory_read_finished = fin;
   assign hif1.pixel_valid = pv;  assign hif1.pixel_data = pd;  assign hif1.input_memory_read_finished = fin;
   assign hif2.pixel_valid = pv;  assign hif2.pixel_data = pd;  assign hif2.input_memory_read_finished = fin;

   histogram_control_param #(.COUNT_WIDTH(16), .SATURATE(1'b1)) dut0 (
      .clock(clock), .reset(reset), .start_histogram(start), .bus(hif0.master),
      .busy(busy[0]), .all_pixel_written(apw[0]), .histogram_done(hd[0]), .pixel_count(pcnt[0]));
   histogram_control_param #(.COUNT_WIDTH(4), .SATURATE(1'b1)) dut1 (
      .clock(clock), .reset(reset), .start_histogram(start), .bus(hif1.master),
      .busy(busy[1]), .all_pixel_written(apw[1]), .histogram_done(hd[1]), .pixel_count(pcnt[1]));
   histogram_control_param #(.COUNT_WIDTH(4), .SATURATE(1'b0)) dut2 (
      .clock(clock), .reset(reset), .start_histogram(start), .bus(hif2.master),
      .busy(busy[2]), .all_pixel_written(apw[2]), .histogram_done(hd[2]), .pixel_count(pcnt[2]));

   // Bin RAMs: registered read, old data returned on a same-cycle write
   logic [15:0] mem0 [256];
   logic [3:0]  mem1 [256];
   logic [3:0]  mem2 [256];

   always @(posedge clock) begin
      if (fill) begin
         for (int i = 0; i < 256; i++) begin
            mem0[i] <= 16'hBEEF; mem1[i] <= 4'hA; mem2[i] <= 4'h6;
         end
      end else begin
         if (hif0.bin_rd_en) hif0.bin_rd_data <= mem0[hif0.bin_rd_addr];
         if (hif0.bin_wr_en) mem0[hif0.bin_wr_addr] <= hif0.bin_wr_data;
         if (hif1.bin_rd_en) hif1.bin_rd_data <= mem1[hif1.bin_rd_addr];
         if (hif1.bin_wr_en) mem1[hif1.bin_wr_addr] <= hif1.bin_wr_data;
         if (hif2.bin_rd_en) hif2.bin_rd_data <= mem2[hif2.bin_rd_addr];
         if (hif2.bin_wr_en) mem2[hif2.bin_wr_addr] <= hif2.bin_wr_data;
      end
   end

   always @(posedge clock) begin
      if (hif0.bin_wr_en) wr_cnt0 <= wr_cnt0 + 1;
      if (hd[0]) done_cnt <= done_cnt + 1;
   end

   typedef struct { int pass_id; int px; int reps; bit fin_last; bit start_pulse; } stim_t;
   typedef struct { int pass_id; int bin; int e16; int e4s; int e4w; } exp_t;

   localparam int NS = 10;
   localparam int NE = 14;
   stim_t stims [NS];
   exp_t  exps  [NE];
   int    exp_pcnt [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic start_pass();
      int bad;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("start_busy", 64'(busy[0]), 64'd1);
      chk("start_pcnt", 64'(pcnt[0]), 64'd0);
      chk("start_apw",  64'(apw[0]),  64'd0);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (!(hif0.bin_wr_en && (int'(hif0.bin_wr_addr) == i) && (hif0.bin_wr_data == 16'd0) &&
               hif1.bin_wr_en && (hif1.bin_wr_data == 4'd0) && !hif0.pixel_ready && busy[0]))
            bad++;
         @(negedge clock);
      end
      chk("clear_seq", 64'(bad), 64'd0);
      chk("clear_end_wr", 64'(hif0.bin_wr_en), 64'd0);
      chk("accum_ready", 64'(hif0.pixel_ready), 64'd1);
   endtask

   task automatic send_px(input int px, input bit fl, input bit sp, inout int stalls);
      int n;
      pv = 1'b1; pd = 8'(px); fin = fl; start = sp;
      n = 0;
      while (!hif0.pixel_ready && n < 8) begin
         stalls++; n++;
         @(negedge clock);
      end
      @(negedge clock);
      pv = 1'b0; fin = 1'b0; start = 1'b0;
   endtask

   task automatic run_pass(input int p);
      int stalls, d0, n;
      bit sent_fin;
      start_pass();
      stalls = 0; sent_fin = 1'b0;
      for (int s = 0; s < NS; s++) begin
         if (stims[s].pass_id == p) begin
            for (int r = 0; r < stims[s].reps; r++)
               send_px(stims[s].px, stims[s].fin_last && (r == stims[s].reps - 1),
                       stims[s].start_pulse && (r == 0), stalls);
            if (stims[s].fin_last) sent_fin = 1'b1;
         end
      end
      chk($sformatf("p%0d_stalls", p), 64'(stalls), 64'd0);
      d0 = done_cnt;
      if (!sent_fin) begin
         fin = 1'b1;
         @(negedge clock);
         fin = 1'b0;
      end
      n = 0;
      while (!apw[0] && n < 10) begin
         @(negedge clock); n++;
      end
      chk($sformatf("p%0d_apw", p), 64'(apw[0]), 64'd1);
      chk($sformatf("p%0d_done_pulse", p), 64'(hd[0]), 64'd1);
      chk($sformatf("p%0d_busy", p), 64'(busy[0]), 64'd0);
      repeat (2) @(negedge clock);
      chk($sformatf("p%0d_done_count", p), 64'(done_cnt - d0), 64'd1);
      chk($sformatf("p%0d_pcnt", p), 64'(pcnt[0]), 64'(exp_pcnt[p]));
      for (int e = 0; e < NE; e++) begin
         if (exps[e].pass_id == p) begin
            chk($sformatf("p%0d_bin%0d_c16", p, exps[e].bin), 64'(mem0[exps[e].bin]), 64'(exps[e].e16));
            chk($sformatf("p%0d_bin%0d_c4s", p, exps[e].bin), 64'(mem1[exps[e].bin]), 64'(exps[e].e4s));
            chk($sformatf("p%0d_bin%0d_c4w", p, exps[e].bin), 64'(mem2[exps[e].bin]), 64'(exps[e].e4w));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls, snap;
      stims = '{
         '{0,   3,  1, 1'b0, 1'b0}, '{0,   7,  1, 1'b0, 1'b1},
         '{0,   3,  1, 1'b0, 1'b0}, '{0, 200,  1, 1'b0, 1'b0},
         '{1,   9, 50, 1'b0, 1'b0}, '{1,   5, 20, 1'b1, 1'b0},
         '{3,   3,  1, 1'b0, 1'b0}, '{3,   7,  1, 1'b0, 1'b0},
         '{3,   3,  1, 1'b0, 1'b0}, '{3, 200,  1, 1'b1, 1'b0}};
      exps = '{
         '{0, 3, 2, 2, 2}, '{0, 7, 1, 1, 1}, '{0, 200, 1, 1, 1}, '{0, 0, 0, 0, 0}, '{0, 255, 0, 0, 0},
         '{1, 9, 50, 15, 2}, '{1, 5, 20, 15, 4}, '{1, 3, 0, 0, 0},
         '{3, 1, 0, 0, 0}, '{3, 3, 2, 2, 2}, '{3, 7, 1, 1, 1}, '{3, 200, 1, 1, 1},
         '{4, 3, 0, 0, 0}, '{4, 9, 0, 0, 0}};
      exp_pcnt = '{4, 70, 0, 4, 0};

      repeat (2) @(negedge clock);
      chk("rst_busy",  64'(busy[0]), 64'd0);
      chk("rst_ready", 64'(hif0.pixel_ready), 64'd0);
      chk("rst_wr_en", 64'(hif0.bin_wr_en), 64'd0);
      chk("rst_apw",   64'(apw[0]), 64'd0);
      chk("rst_done",  64'(hd[0]), 64'd0);
      chk("rst_pcnt",  64'(pcnt[0]), 64'd0);
      fill = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clock);

      run_pass(0);
      chk("done_holds_apw", 64'(apw[0]), 64'd1);
      run_pass(1);

      // Abort mid-accumulation with an asynchronous reset
      start_pass();
      stalls = 0;
      for (int r = 0; r < 5; r++) send_px(1, 1'b0, 1'b0, stalls);
      pv = 1'b1; pd = 8'd1;
      #2 reset = 1'b0;
      #1;
      chk("abort_busy",  64'(busy[0]), 64'd0);
      chk("abort_wr_en", 64'(hif0.bin_wr_en), 64'd0);
      chk("abort_rd_en", 64'(hif0.bin_rd_en), 64'd0);
      chk("abort_pcnt",  64'(pcnt[0]), 64'd0);
      snap = wr_cnt0;
      pv = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (5) @(negedge clock);
      chk("abort_no_writes", 64'(wr_cnt0 - snap), 64'd0);
      chk("abort_idle_busy", 64'(busy[0]), 64'd0);

      run_pass(3);
      run_pass(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/histogram_control_param.md
Name: histogram_control_param

Overview:
- Parametrised successor to the fixed histogram controller. Sequences a full histogram pass: clear bin memory, accumulate a pixel stream with read-modify-write, signal completion.
- Sits between the input-memory reader (pixel source) and a single-port-read / single-port-write bin RAM.
- Adds the following over the previous generation:
  - Configurable pixel, bin and count widths.
  - Selectable saturating or wrapping counts.
  - Back-to-back same-bin hazard forwarding.
  - Status outputs.

Parameters:
PIXEL_WIDTH, 8, bits per input pixel
BIN_BITS, 8, log2 of bin count; must be <= PIXEL_WIDTH; bin index = pixel_data >> (PIXEL_WIDTH-BIN_BITS)
COUNT_WIDTH, 16, width of each bin counter
SATURATE, 1, 1 = counts stick at 2^COUNT_WIDTH-1; 0 = counts wrap modulo 2^COUNT_WIDTH
PIXCNT_WIDTH, 20, width of the accepted-pixel counter

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start_histogram  in  1  level or pulse; sampled in IDLE and DONE only
pixel_valid  in  1  source has a pixel on pixel_data
pixel_data  in  PIXEL_WIDTH  pixel value
pixel_ready  out  1  controller accepts the pixel this cycle
input_memory_read_finished  in  1  source has presented its last pixel; latched
bin_rd_en  out  1  bin RAM read strobe
bin_rd_addr  out  BIN_BITS  bin RAM read address
bin_rd_data  in  COUNT_WIDTH  RAM read data, valid 1 cycle after bin_rd_en; returns old data on same-cycle write
bin_wr_en  out  1  bin RAM write strobe
bin_wr_addr  out  BIN_BITS  bin RAM write address
bin_wr_data  out  COUNT_WIDTH  bin RAM write data
busy  out  1  high in CLEAR, ACCUM and DRAIN
all_pixel_written  out  1  high in DONE
histogram_done  out  1  one-cycle pulse on entry to DONE
pixel_count  out  PIXCNT_WIDTH  pixels accepted in the current pass

Behaviour:
- Reset (asynchronous, active-low):
  - FSM goes to IDLE.
  - All outputs 0, pixel_count 0, finished latch cleared, pipeline emptied.
  - Reset asserted mid-pass aborts immediately. No further RAM writes until a new start.
- States: IDLE, CLEAR, ACCUM, DRAIN, DONE.
- IDLE -> CLEAR when start_histogram=1.
  - On entry: pixel_count<=0, finished latch<=0, clear address<=0.
- CLEAR:
  - Each cycle: bin_wr_en=1, bin_wr_addr=clear_addr, bin_wr_data=0.
  - Takes exactly 2^BIN_BITS cycles, then -> ACCUM.
  - pixel_ready=0 throughout.
- ACCUM:
  - pixel_ready=1 while the finished latch is clear.
  - Accept when pixel_valid & pixel_ready.
  - Stage 1 (accept cycle t): bin_rd_en=1, bin_rd_addr=bin(pixel_data); register the bin; pixel_count+1.
  - Stage 2 (cycle t+1):
    - base = forwarded value if the stage-2 bin equals the bin written in the previous cycle, else bin_rd_data.
    - new = base+1, or base unchanged when SATURATE=1 and base is all-ones.
    - bin_wr_en=1, bin_wr_addr=bin, bin_wr_data=new.
    - Register (bin, new) as the forwarding source.
  - Throughput: 1 pixel/cycle sustained, including runs of identical pixels.
- input_memory_read_finished:
  - Latched when high in ACCUM.
  - A pixel presented with pixel_valid in the same cycle is still accepted.
  - Afterwards pixel_ready=0 and the FSM -> DRAIN.
- DRAIN: completes any outstanding stage-2 write (0 or 1 cycle), then -> DONE.
- DONE:
  - all_pixel_written=1; histogram_done pulses on the entry cycle only; pixel_count holds.
  - start_histogram=1 -> CLEAR, beginning a new pass.
- start_histogram while busy is ignored.
- pixel_count saturates at all-ones and does not wrap.
- Zero-pixel pass (finished asserted on the first ACCUM cycle, no pixels): all bins 0, pixel_count 0, DONE reached normally.

Test Plan:
- Reset release, then start -> exactly 256 consecutive writes of 0 to addresses 0..255. busy=1 from the cycle after start. pixel_ready=0 during CLEAR.
- Stream pixels 3, 7, 3, 200, then finished -> bins 3=2, 7=1, 200=1, all others 0. pixel_count=4. histogram_done pulses once. all_pixel_written=1.
- 50 back-to-back pixels of value 9 at 1 pixel/cycle -> bin 9=50, with no stall and no lost increment (forwarding exercised).
- COUNT_WIDTH=4:
  - SATURATE=1, 20 pixels of value 5 -> bin 5=15.
  - SATURATE=0, same stimulus -> bin 5=4.
- Reset asserted mid-ACCUM -> outputs 0 asynchronously with no further writes. A new start re-clears memory and recomputes correctly.
- Start pulsed during ACCUM is ignored. Start in DONE launches a second pass: pixel_count restarts at 0 and all_pixel_written drops.
